vc_dest_scheduler: RTL

//  Drains the two virtual-channel FIFOs (VC0, VC1) and routes each word to destination FIFO D0 or D1.

---
 rtl/vc_dest_scheduler_if.sv | 42 ++++
 rtl/vc_dest_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vc_dest_scheduler_if.sv
// vc_dest_scheduler_if
//   Bundles the VC-side FIFO handshake, the destination-side FIFO handshake
//   and the status flags of the VC -> destination scheduler.
//   Parameter: BW - word width.
//   Modports:
//     master - the scheduler: reads VC flags/data and D flags, drives
//              VC0_rd/VC1_rd, D0_wr/D1_wr, D_data_in and the status flags.
//     slave  - the surrounding FIFO stages / environment (mirror image).
interface vc_dest_scheduler_if #(
  parameter int BW = 6
) ();
  logic          VC0_empty;
  logic          VC1_empty;
  logic [BW-1:0] VC0_data_out;
  logic [BW-1:0] VC1_data_out;
  logic          D0_almost_full;
  logic          D1_almost_full;
  logic          D0_full;
  logic          D1_full;
  logic          VC0_rd;
  logic          VC1_rd;
  logic          D0_wr;
  logic          D1_wr;
  logic [BW-1:0] D_data_in;
  logic          idle_out;
  logic          active_out;
  logic          error_out;

  modport master (
    input  VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
    input  D0_almost_full, D1_almost_full, D0_full, D1_full,
    output VC0_rd, VC1_rd, D0_wr, D1_wr, D_data_in,
    output idle_out, active_out, error_out
  );

  modport slave (
    output VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
    output D0_almost_full, D1_almost_full, D0_full, D1_full,
    input  VC0_rd, VC1_rd, D0_wr, D1_wr, D_data_in,
    input  idle_out, active_out, error_out
  );
endinterface

// File: rtl/vc_dest_scheduler.sv
// vc_dest_scheduler
//   Drains the VC0/VC1 FIFOs and routes every word to destination FIFO D0 or
//   D1 according to bit DEST_BIT of the word. VC0 has priority over VC1.
//   Read-to-write pipeline: rd in cycle N, VC data captured at the end of
//   N+1, Dx_wr/D_data_in asserted in N+2; one word per cycle sustained.
//   Optional feature macro WRR_EN: weighted round robin (VC0 gets up to
//   WEIGHT_VC0 consecutive grants while VC1 waits, then VC1 gets one).
//   Without WRR_EN: strict priority, VC1 read only when VC0 is empty.
// Ports:
//   clk     - clock, all logic on posedge
//   reset_L - asynchronous active-low reset
//   init    - synchronous soft restart (in-flight words still complete)
//   bus     - vc_dest_scheduler_if.master: VC flags/data, D flags,
//             rd/wr strobes, D_data_in, idle/active/error status
module vc_dest_scheduler #(
  parameter int BW         = 6,
  parameter int DEST_BIT   = 4,
  parameter int WEIGHT_VC0 = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  vc_dest_scheduler_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  // Reject weights the 4-bit grant counter cannot represent.
  if (WEIGHT_VC0 < 1 || WEIGHT_VC0 > 15) begin : g_bad_weight
    $error("vc_dest_scheduler: WEIGHT_VC0 must be in 1..15");
  end

  state_t        state_r, state_nxt_s;
  logic          vc0_rd_r, vc1_rd_r;
  logic          p1_vc0_r, p1_vc1_r;
  logic          d0_wr_r, d1_wr_r;
  logic [BW-1:0] d_data_r;
  logic          idle_r, active_r, error_r;

  logic          af_s, in_flight_s;
  logic          gnt0_s, gnt1_s;
  logic [BW-1:0] cap_word_s;
  logic          cap_vld_s, dest_s;
  logic          d0_wr_nxt_s, d1_wr_nxt_s, drop_s;
  logic          error_nxt_s, idle_nxt_s, active_nxt_s;

  assign af_s        = bus.D0_almost_full | bus.D1_almost_full;
  assign in_flight_s = vc0_rd_r | vc1_rd_r | p1_vc0_r | p1_vc1_r;

  // FSM next-state logic; init forces IDLE from any state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!init && (!bus.VC0_empty || !bus.VC1_empty)) state_nxt_s = ST_ACTIVE;
        else                                              state_nxt_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (init)                                                         state_nxt_s = ST_IDLE;
        else if (af_s)                                                    state_nxt_s = ST_PAUSE;
        else if (bus.VC0_empty && bus.VC1_empty && !in_flight_s)          state_nxt_s = ST_IDLE;
        else                                                              state_nxt_s = ST_ACTIVE;
      end
      ST_PAUSE: begin
        if (init)       state_nxt_s = ST_IDLE;
        else if (!af_s) state_nxt_s = ST_ACTIVE;
        else            state_nxt_s = ST_PAUSE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

`ifdef WRR_EN
  localparam logic [3:0] WEIGHT_L = 4'(WEIGHT_VC0);
  logic [3:0] wcnt_r, wcnt_nxt_s;

  // Weighted grant: VC0 yields to a waiting VC1 after WEIGHT_VC0 grants in a row.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_nxt_s == ST_ACTIVE && !af_s) begin
      if (!bus.VC0_empty && (bus.VC1_empty || wcnt_r < WEIGHT_L)) gnt0_s = 1'b1;
      else if (!bus.VC1_empty)                                    gnt1_s = 1'b1;
      else                                                        gnt1_s = 1'b0;
    end else begin
      gnt0_s = 1'b0;
    end
  end

  // Consecutive-VC0-grant counter; only counts while VC1 is waiting.
  always_comb begin
    wcnt_nxt_s = wcnt_r;
    if (init || bus.VC0_empty || gnt1_s)   wcnt_nxt_s = 4'd0;
    else if (gnt0_s && !bus.VC1_empty)     wcnt_nxt_s = wcnt_r + 4'd1;
    else                                   wcnt_nxt_s = wcnt_r;
  end

  // Weight counter register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) wcnt_r <= 4'd0;
    else          wcnt_r <= wcnt_nxt_s;
  end
`else
  // Strict priority grant: VC1 only when VC0 is empty.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_nxt_s == ST_ACTIVE && !af_s) begin
      if (!bus.VC0_empty)      gnt0_s = 1'b1;
      else if (!bus.VC1_empty) gnt1_s = 1'b1;
      else                     gnt1_s = 1'b0;
    end else begin
      gnt0_s = 1'b0;
    end
  end
`endif

  // Write stage: route the captured word, drop it if its target is full.
  always_comb begin
    cap_vld_s   = p1_vc0_r | p1_vc1_r;
    cap_word_s  = p1_vc1_r ? bus.VC1_data_out : bus.VC0_data_out;
    dest_s      = cap_word_s[DEST_BIT];
    d0_wr_nxt_s = cap_vld_s & ~dest_s & ~bus.D0_full;
    d1_wr_nxt_s = cap_vld_s &  dest_s & ~bus.D1_full;
    drop_s      = cap_vld_s & (dest_s ? bus.D1_full : bus.D0_full);
    if (init) error_nxt_s = 1'b0;
    else      error_nxt_s = error_r | drop_s;
    // Idle next cycle only if nothing is read, captured or written then.
    idle_nxt_s   = (state_nxt_s == ST_IDLE) & ~gnt0_s & ~gnt1_s & ~vc0_rd_r & ~vc1_rd_r
                   & ~d0_wr_nxt_s & ~d1_wr_nxt_s;
    active_nxt_s = gnt0_s | gnt1_s | d0_wr_nxt_s | d1_wr_nxt_s;
  end

  // State, pipeline and output registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r  <= ST_IDLE;
      vc0_rd_r <= 1'b0;
      vc1_rd_r <= 1'b0;
      p1_vc0_r <= 1'b0;
      p1_vc1_r <= 1'b0;
      d0_wr_r  <= 1'b0;
      d1_wr_r  <= 1'b0;
      d_data_r <= '0;
      idle_r   <= 1'b1;
      active_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      vc0_rd_r <= gnt0_s;
      vc1_rd_r <= gnt1_s;
      p1_vc0_r <= vc0_rd_r;
      p1_vc1_r <= vc1_rd_r;
      d0_wr_r  <= d0_wr_nxt_s;
      d1_wr_r  <= d1_wr_nxt_s;
      if (cap_vld_s) d_data_r <= cap_word_s;
      else           d_data_r <= d_data_r;
      idle_r   <= idle_nxt_s;
      active_r <= active_nxt_s;
      error_r  <= error_nxt_s;
    end
  end

  assign bus.VC0_rd     = vc0_rd_r;
  assign bus.VC1_rd     = vc1_rd_r;
  assign bus.D0_wr      = d0_wr_r;
  assign bus.D1_wr      = d1_wr_r;
  assign bus.D_data_in  = d_data_r;
  assign bus.idle_out   = idle_r;
  assign bus.active_out = active_r;
  assign bus.error_out  = error_r;

endmodule
